sipo_deframer: RTL and testbench

Serial-to-parallel receive stage that sits directly downstream of the team's PISO shift register and consumes its LSB-first serial stream. It samples one bit per qualified clock, counts N bits into a word, and presents the assembled word on a valid/ready output port. A one-word holding register decouples word assembly from the consumer. Words that complete while the holding register is still full are dropped and flagged on a sticky overrun bit.

---
 rtl/sipo_deframer.sv | 100 ++++++++++
 tb/tb_sipo_deframer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// sipo_deframer
//   Serial-to-parallel receive stage for an LSB-first serial stream (the
//   companion PISO's serial_out). Accepted bits are shifted into an assembly
//   register; every N accepted bits form a word that is moved into a one-word
//   holding register exposed on a valid/ready port. A word that completes
//   while the holding register is full and not being drained is dropped and
//   recorded on the sticky overrun flag.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   bit_valid    serial_in carries a valid bit this cycle
//   serial_in    serial data, LSB of each word first
//   start        frame sync: discard partial word and restart the bit count
//   clr_overrun  clear the overrun flag (a same-cycle overrun wins)
//   data_out     word held in the holding register
//   data_valid   holding register is full
//   data_ready   consumer takes data_out this cycle
//   overrun      sticky: a completed word was dropped
//   busy         a partial word is in progress
module sipo_deframer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_valid,
  input  logic         serial_in,
  input  logic         start,
  input  logic         clr_overrun,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] r_count;
  logic [N-1:0]  r_asm;
  logic [N-1:0]  r_data_out;
  logic          r_data_valid;
  logic          r_overrun;

  logic [CW-1:0] w_count_base;
  logic [N-1:0]  w_asm_next;
  logic          w_word_done;
  logic          w_drain;
  logic          w_drop;

  // start restarts the count before the current bit is considered, so a bit
  // arriving with start becomes bit 0 of the new word.
  always_comb begin
    w_count_base = start ? '0 : r_count;
    w_asm_next   = {serial_in, r_asm[N-1:1]};
    w_word_done  = bit_valid && (w_count_base == CW'(N - 1));
    w_drain      = r_data_valid && data_ready;
    w_drop       = w_word_done && r_data_valid && !data_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_asm   <= '0;
    end else if (bit_valid) begin
      r_asm   <= w_asm_next;
      r_count <= w_word_done ? '0 : w_count_base + CW'(1);
    end else if (start) begin
      r_count <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else if (w_word_done && (!r_data_valid || data_ready)) begin
      r_data_out   <= w_asm_next;
      r_data_valid <= 1'b1;
    end else if (w_drain) begin
      r_data_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_count != '0);

endmodule

// File: tb/tb_sipo_deframer.sv
module tb_sipo_deframer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_valid = 1'b0;
  logic         serial_in = 1'b0;
  logic         start = 1'b0;
  logic         clr_overrun = 1'b0;
  logic         data_ready = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         overrun;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit en_cmp = 1'b0;

  sipo_deframer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .start      (start),
    .clr_overrun(clr_overrun),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: received bits of the current frame, plus the word the
  // consumer should currently see.
  bit m_bits[$];
  int m_data  = 0;
  bit m_valid = 1'b0;
  bit m_ovr   = 1'b0;

  always @(posedge clk) begin
    int  word;
    bit  done;
    bit  was_valid;
    if (rst) begin
      m_bits.delete();
      m_data  = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      done = 1'b0;
      word = 0;
      was_valid = m_valid;
      if (start) m_bits.delete();
      if (bit_valid) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == N) begin
          for (int i = 0; i < N; i++) word += int'(m_bits[i]) << i;
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (clr_overrun) m_ovr = 1'b0;
      if (done) begin
        if (was_valid && !data_ready) m_ovr = 1'b1;
        else begin
          m_data  = word;
          m_valid = 1'b1;
        end
      end else if (was_valid && data_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("cmp_data_out", int'(data_out), m_data);
      chk("cmp_data_valid", int'(data_valid), int'(m_valid));
      chk("cmp_overrun", int'(overrun), int'(m_ovr));
      chk("cmp_busy", int'(busy), int'(m_bits.size() != 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap);
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      serial_in = w[i];
      step();
      bit_valid = 1'b0;
      if (i < N - 1) repeat (gap) step();
    end
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    serial_in = b;
    step();
    bit_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] piso;

    // Reset state
    step();
    step();
    en_cmp = 1'b1;
    rst = 1'b0;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);

    // Basic word 1,0,1,1 -> D, valid for exactly one cycle
    data_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("basic_not_yet_valid", int'(data_valid), 0);
    send_bit(1'b1);
    chk("basic_data", int'(data_out), 'hD);
    chk("basic_model_data", m_data, 'hD);
    chk("basic_valid", int'(data_valid), 1);
    step();
    chk("basic_valid_one_cycle", int'(data_valid), 0);
    chk("basic_data_kept", int'(data_out), 'hD);

    // Chained with a PISO loaded with A
    piso = 4'hA;
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      serial_in = piso[0];
      piso = piso >> 1;
      step();
    end
    bit_valid = 1'b0;
    chk("piso_data", int'(data_out), 'hA);
    chk("piso_valid", int'(data_valid), 1);
    step();

    // Backpressure / overrun: 3 then C back-to-back with data_ready low
    data_ready = 1'b0;
    send_word(4'h3, 0);
    chk("bp_first_data", int'(data_out), 'h3);
    chk("bp_first_ovr", int'(overrun), 0);
    send_word(4'hC, 0);
    chk("bp_hold_data", int'(data_out), 'h3);
    chk("bp_hold_valid", int'(data_valid), 1);
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_model_ovr", int'(m_ovr), 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("bp_clr", int'(overrun), 0);
    data_ready = 1'b1;
    step();
    chk("bp_drained_valid", int'(data_valid), 0);
    chk("bp_drained_data", int'(data_out), 'h3);

    // Start resync: 1,1 then start, then 0,1,1,0 -> 6
    send_bit(1'b1);
    send_bit(1'b1);
    chk("sync_busy", int'(busy), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sync_busy_cleared", int'(busy), 0);
    send_bit(1'b0);
    chk("sync_busy_new", int'(busy), 1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("sync_data", int'(data_out), 'h6);
    chk("sync_valid", int'(data_valid), 1);
    step();
    chk("sync_one_word", int'(data_valid), 0);

    // Gapped word 5, then hold it and drain in the same cycle 9 completes
    send_word(4'h5, 2);
    data_ready = 1'b0;
    chk("gap_data", int'(data_out), 'h5);
    chk("gap_valid", int'(data_valid), 1);
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      serial_in = (i == 0 || i == 3);
      if (i == N - 1) data_ready = 1'b1;
      else begin
        chk("gap_hold_data", int'(data_out), 'h5);
        chk("gap_hold_valid", int'(data_valid), 1);
      end
      step();
    end
    bit_valid = 1'b0;
    data_ready = 1'b0;
    chk("simul_data", int'(data_out), 'h9);
    chk("simul_valid", int'(data_valid), 1);
    chk("simul_no_ovr", int'(overrun), 0);

    // Overrun set wins over clr_overrun in the same cycle
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      serial_in = 1'b1;
      if (i == N - 1) clr_overrun = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    clr_overrun = 1'b0;
    chk("set_wins_ovr", int'(overrun), 1);
    chk("set_wins_data", int'(data_out), 'h9);

    // Reset mid-stream: partial word lost, next 4 bits form a fresh word
    data_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_valid", int'(data_valid), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    chk("mid_rst_busy", int'(busy), 0);
    send_word(4'h7, 0);
    chk("mid_rst_fresh", int'(data_out), 'h7);
    chk("mid_rst_fresh_valid", int'(data_valid), 1);
    step();
    step();

    en_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
